// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_pkg;

   localparam int DMEM_DATA_W    = 32;
   localparam int DMEM_MEM_WORDS = 256;
   localparam int DMEM_MAX_WAIT  = 4;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RESP_CPU,
      RESP_DMA
   } resp_state_e;

endpackage

// File: rtl/dmem_prio_sel.sv
// Fixed CPU-priority winner select with a DMA starvation counter that
// forces a DMA grant after MAX_WAIT consecutive lost cycles.
module dmem_prio_sel
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cpu_req_i,
   input  logic       dma_req_i,
   output logic [1:0] gnt_o,
   output logic       winner_o
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       dma_win, cpu_win;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      gnt_o      = '0;
      wait_cnt_d = wait_cnt_q;
      dma_win    = rst_i & dma_req_i & (~cpu_req_i | (wait_cnt_q == MAX_WAIT_C));
      cpu_win    = rst_i & cpu_req_i & ~dma_win;
      gnt_o[PORT_CPU] = cpu_win;
      gnt_o[PORT_DMA] = dma_win;
      winner_o   = dma_win ? PORT_DMA : PORT_CPU;
      if (~dma_req_i | dma_win) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q < MAX_WAIT_C) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter for a single-ported data memory with registered read return.
// Optional address bounds checking and sticky err_o under `DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int MEM_WORDS = DMEM_MEM_WORDS,
   parameter int MAX_WAIT  = DMEM_MAX_WAIT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_stall_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [31:0]       dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic              dma_rvalid_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic [31:0]       mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_write_o,
   output logic              mem_read_o,
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   output logic              err_o,
`endif
   input  logic [DATA_W-1:0] mem_rdata_i
);

   logic [1:0]        gnt;
   logic              winner;
   logic              any_gnt, read_gnt, oob;
   logic              win_we;
   logic [31:0]       win_addr;
   logic [DATA_W-1:0] win_wdata;

   resp_state_e       state_q, state_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

   dmem_prio_sel #(
      .MAX_WAIT (MAX_WAIT)
   ) u_prio_sel (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cpu_req_i (cpu_req_i),
      .dma_req_i (dma_req_i),
      .gnt_o     (gnt),
      .winner_o  (winner)
   );

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);
   logic err_q, err_d;

   assign oob   = (win_addr[31:2] >= MEM_WORDS_W);
   assign err_d = err_q | (any_gnt & oob);
   assign err_o = err_q;
`else
   assign oob = 1'b0;
`endif

   always_comb begin
      win_we    = (winner == PORT_DMA) ? dma_we_i    : cpu_we_i;
      win_addr  = (winner == PORT_DMA) ? dma_addr_i  : cpu_addr_i;
      win_wdata = (winner == PORT_DMA) ? dma_wdata_i : cpu_wdata_i;

      cpu_gnt_o   = gnt[PORT_CPU];
      dma_gnt_o   = gnt[PORT_DMA];
      cpu_stall_o = cpu_req_i & ~gnt[PORT_CPU];
      any_gnt     = |gnt;
      read_gnt    = any_gnt & ~win_we;

      // Out-of-range accesses are still granted but never strobe the memory.
      mem_write_o = any_gnt & win_we & ~oob;
      mem_read_o  = any_gnt & ~win_we & ~oob;

      mem_addr_d  = any_gnt ? {2'b00, win_addr[31:2]} : mem_addr_q;
      mem_wdata_d = any_gnt ? win_wdata : mem_wdata_q;
      mem_addr_o  = mem_addr_d;
      mem_wdata_o = mem_wdata_d;

      state_d = IDLE;
      rdata_d = rdata_q;
      if (read_gnt) begin
         state_d = (winner == PORT_DMA) ? RESP_DMA : RESP_CPU;
         rdata_d = oob ? '0 : mem_rdata_i;
      end

      // Gating with rst_i drops a response that was in flight when reset arrived.
      cpu_rvalid_o = rst_i & (state_q == RESP_CPU);
      dma_rvalid_o = rst_i & (state_q == RESP_DMA);
      cpu_rdata_d  = cpu_rvalid_o ? rdata_q : cpu_rdata_q;
      dma_rdata_d  = dma_rvalid_o ? rdata_q : dma_rdata_q;
      cpu_rdata_o  = cpu_rdata_d;
      dma_rdata_o  = dma_rdata_d;
   end

   // NOTE: the held bus and read-data registers are reset so outputs are defined (0) before any grant.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle model predicts grants/strobes and queues read responses.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int DATA_W    = 32;
   localparam int MEM_WORDS = 256;
   localparam int MAX_WAIT  = 4;

   typedef struct packed {
      logic              req;
      logic              we;
      logic [31:0]       addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef struct {
      logic              port;
      logic [DATA_W-1:0] data;
   } rsp_t;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              cpu_req_i, cpu_we_i, dma_req_i, dma_we_i;
   logic [31:0]       cpu_addr_i, dma_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i, dma_wdata_i;
   logic              cpu_gnt_o, cpu_stall_o, cpu_rvalid_o;
   logic              dma_gnt_o, dma_rvalid_o;
   logic [DATA_W-1:0] cpu_rdata_o, dma_rdata_o;
   logic [31:0]       mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
   logic              mem_write_o, mem_read_o;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   logic              err_o;
`endif

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(
      .DATA_W    (DATA_W),
      .MEM_WORDS (MEM_WORDS),
      .MAX_WAIT  (MAX_WAIT)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_gnt_o    (cpu_gnt_o),
      .cpu_stall_o  (cpu_stall_o),
      .cpu_rvalid_o (cpu_rvalid_o),
      .cpu_rdata_o  (cpu_rdata_o),
      .dma_req_i    (dma_req_i),
      .dma_we_i     (dma_we_i),
      .dma_addr_i   (dma_addr_i),
      .dma_wdata_i  (dma_wdata_i),
      .dma_gnt_o    (dma_gnt_o),
      .dma_rvalid_o (dma_rvalid_o),
      .dma_rdata_o  (dma_rdata_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_write_o  (mem_write_o),
      .mem_read_o   (mem_read_o),
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      .err_o        (err_o),
`endif
      .mem_rdata_i  (mem_rdata_i)
   );

   // Memory device attached to the arbiter: write on strobe, combinational read.
   logic [DATA_W-1:0] mem [MEM_WORDS];
   always @(posedge clk_i) begin
      if (mem_write_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
   end
   assign mem_rdata_i = mem[mem_addr_o[7:0]];

   int                n_checks = 0;
   int                n_errors = 0;
   req_t              cpu_s, dma_s;
   rsp_t              exp_q[$];
   logic [DATA_W-1:0] exp_mem [MEM_WORDS];
   int                m_wcnt;
   logic [31:0]       m_addr_hold;
   logic [DATA_W-1:0] m_wdata_hold, m_cpu_last, m_dma_last;
   logic              m_rv_cpu, m_rv_dma, m_known, m_err, m_cpu_g, m_dma_g;
   logic              obs_dma_gnt, obs_dma_rvalid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic req_t rd(input logic [31:0] addr);
      rd = '{req: 1'b1, we: 1'b0, addr: addr, wdata: '0};
   endfunction

   function automatic req_t wr(input logic [31:0] addr, input logic [DATA_W-1:0] data);
      wr = '{req: 1'b1, we: 1'b1, addr: addr, wdata: data};
   endfunction

   function automatic req_t rnd_req();
      rnd_req.req   = ($urandom_range(0, 2) != 0);
      rnd_req.we    = 1'($urandom_range(0, 1));
      rnd_req.addr  = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      rnd_req.wdata = $urandom;
   endfunction

   // Called at the falling edge: compare DUT against the model, then advance the model one cycle.
   task automatic evaluate();
      logic              dg, cg, g, we, oob, exp_rvc, exp_rvd;
      logic [31:0]       addr;
      logic [29:0]       word;
      logic [DATA_W-1:0] wd;
      rsp_t              e;

      dg   = rst_i && dma_s.req && (!cpu_s.req || m_wcnt == MAX_WAIT);
      cg   = rst_i && cpu_s.req && !dg;
      g    = cg || dg;
      we   = dg ? dma_s.we : cpu_s.we;
      addr = dg ? dma_s.addr : cpu_s.addr;
      wd   = dg ? dma_s.wdata : cpu_s.wdata;
      word = addr[31:2];
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      oob  = g && (word >= 30'(MEM_WORDS));
`else
      oob  = 1'b0;
`endif
      obs_dma_gnt    = dma_gnt_o;
      obs_dma_rvalid = dma_rvalid_o;

      check("cpu_gnt", cpu_gnt_o, cg);
      check("dma_gnt", dma_gnt_o, dg);
      check("cpu_stall", cpu_stall_o, cpu_s.req && !cg);
      check("mem_write", mem_write_o, g && we && !oob);
      check("mem_read", mem_read_o, g && !we && !oob);
      if (g || m_known) begin
         check("mem_addr", mem_addr_o, g ? {2'b00, word} : m_addr_hold);
         check("mem_wdata", mem_wdata_o, g ? wd : m_wdata_hold);
      end

      if (m_known) begin
         exp_rvc = m_rv_cpu && rst_i;
         exp_rvd = m_rv_dma && rst_i;
         check("cpu_rvalid", cpu_rvalid_o, exp_rvc);
         check("dma_rvalid", dma_rvalid_o, exp_rvd);
         if ((exp_rvc || exp_rvd) && exp_q.size() == 0) begin
            check("rsp_queue_underflow", 1, 0);
         end else if (exp_rvc || exp_rvd) begin
            e = exp_q.pop_front();
            if (exp_rvc) begin
               check("cpu_rdata", cpu_rdata_o, e.data);
               m_cpu_last = e.data;
            end else begin
               check("dma_rdata", dma_rdata_o, e.data);
               m_dma_last = e.data;
            end
         end
         if (!exp_rvc) check("cpu_rdata_hold", cpu_rdata_o, m_cpu_last);
         if (!exp_rvd) check("dma_rdata_hold", dma_rdata_o, m_dma_last);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
         check("err", err_o, m_err);
`endif
      end

      m_cpu_g = cg;
      m_dma_g = dg;

      if (!rst_i) begin
         m_wcnt       = 0;
         m_addr_hold  = '0;
         m_wdata_hold = '0;
         m_cpu_last   = '0;
         m_dma_last   = '0;
         m_rv_cpu     = 1'b0;
         m_rv_dma     = 1'b0;
         m_err        = 1'b0;
         m_known      = 1'b1;
         exp_q.delete();
      end else begin
         if (!dma_s.req || dg) m_wcnt = 0;
         else if (m_wcnt < MAX_WAIT) m_wcnt++;
         if (g) begin
            m_addr_hold  = {2'b00, word};
            m_wdata_hold = wd;
            if (!we) exp_q.push_back('{port: (dg ? PORT_DMA : PORT_CPU),
                                       data: (oob ? '0 : exp_mem[word[7:0]])});
            else if (!oob) exp_mem[word[7:0]] = wd;
         end
         m_rv_cpu = cg && !we;
         m_rv_dma = dg && !we;
         if (oob) m_err = 1'b1;
      end
   endtask

   task automatic step(input logic rst);
      rst_i       = rst;
      cpu_req_i   = cpu_s.req;
      cpu_we_i    = cpu_s.we;
      cpu_addr_i  = cpu_s.addr;
      cpu_wdata_i = cpu_s.wdata;
      dma_req_i   = dma_s.req;
      dma_we_i    = dma_s.we;
      dma_addr_i  = dma_s.addr;
      dma_wdata_i = dma_s.wdata;
      @(negedge clk_i);
      evaluate();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int first, second;
      for (int i = 0; i < MEM_WORDS; i++) begin
         mem[i]     = '0;
         exp_mem[i] = '0;
      end
      cpu_s   = '0;
      dma_s   = '0;
      m_known = 1'b0;
      m_wcnt  = 0;
      m_err   = 1'b0;
      rst_i   = 1'b0;
      @(posedge clk_i);
      #1;
      step(1'b0);
      step(1'b0);

      // DMA loads a word, CPU reads it back.
      dma_s = wr(32'h14, 32'hDEADBEEF); step(1'b1);
      dma_s = '0;
      cpu_s = rd(32'h14);               step(1'b1);
      cpu_s = '0;                       step(1'b1);

      // Write then read the same word on consecutive cycles.
      cpu_s = wr(32'h40, 32'h12345678); step(1'b1);
      cpu_s = rd(32'h40);               step(1'b1);
      cpu_s = '0;                       step(1'b1);

      // Alternating single-port traffic, low address bits set.
      cpu_s = rd(32'h17);               step(1'b1);
      cpu_s = '0;
      dma_s = rd(32'h42);               step(1'b1);
      dma_s = wr(32'h1B, 32'hA5A5_0F0F); step(1'b1);
      dma_s = '0;
      cpu_s = rd(32'h18);               step(1'b1);
      cpu_s = '0;                       step(1'b1);

      // Continuous contention: DMA must be forced in every MAX_WAIT+1 cycles.
      cpu_s  = rd(32'h14);
      dma_s  = rd(32'h40);
      first  = -1;
      second = -1;
      for (int k = 0; k < 12; k++) begin
         step(1'b1);
         if (obs_dma_gnt && first < 0) first = k;
         else if (obs_dma_gnt && second < 0) second = k;
      end
      check("dma_forced_first", 64'(first), 64'(MAX_WAIT));
      check("dma_forced_second", 64'(second), 64'(2 * MAX_WAIT + 1));
      cpu_s = wr(32'h80, 32'h1111_2222);
      dma_s = wr(32'h84, 32'h3333_4444);
      repeat (7) step(1'b1);
      cpu_s = rd(32'h84);
      dma_s = rd(32'h80);
      repeat (3) step(1'b1);
      cpu_s = '0;
      dma_s = '0;

      // Idle: no strobes, bus holds, no responses.
      repeat (10) step(1'b1);

      // Reset in the cycle after a DMA read grant drops the response.
      dma_s = rd(32'h14); step(1'b1);
      dma_s = '0;         step(1'b0);
      check("rst_drops_dma_rvalid", obs_dma_rvalid, 1'b0);
      repeat (2) step(1'b1);

      // Reset clears a partly counted wait.
      cpu_s = rd(32'h14);
      dma_s = rd(32'h40);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      first = -1;
      for (int k = 0; k < 6; k++) begin
         step(1'b1);
         if (obs_dma_gnt && first < 0) first = k;
      end
      check("dma_forced_after_reset", 64'(first), 64'(MAX_WAIT));
      cpu_s = '0;
      dma_s = '0;
      step(1'b1);

      // Random traffic honouring the hold-until-granted rule.
      repeat (300) begin
         if (!cpu_s.req || m_cpu_g) cpu_s = rnd_req();
         if (!dma_s.req || m_dma_g) dma_s = rnd_req();
         step(1'b1);
      end
      cpu_s = '0;
      dma_s = '0;
      repeat (2) step(1'b1);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      // Out-of-range read: granted, no strobes, zero data, sticky error until reset.
      cpu_s = rd(32'h400); step(1'b1);
      cpu_s = '0;          step(1'b1);
      cpu_s = rd(32'h14);  step(1'b1);
      cpu_s = '0;
      repeat (3) step(1'b1);
      step(1'b0);
      repeat (2) step(1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
